interrupt_take_sequencer: RTL and testbench

Sequencer that consumes the interrupt router's decision (`int_o`, `int_type`, `new_mode`) and turns it into a precise architectural trap. It stops dispatch, waits for the reorder buffer to drain, then latches the cause and resume PC. It issues one CSR trap-write pulse and redirects fetch to the `mtvec`/`stvec` target. It sits between the interrupt router and the CSR file / frontend redirect path.

---
 rtl/interrupt_take_sequencer.sv | 126 ++++++++++++
 tb/tb_interrupt_take_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_take_sequencer.sv
// Interrupt take sequencer: turns the router's interrupt decision into a precise trap.
// Halts dispatch, waits for the ROB to drain, latches cause/mode/epc, pulses the CSR
// trap write once and then holds a fetch redirect until it is accepted.
// Optional build macro: INT_VECTORED_EN enables vectored trap targets (tvec[1:0] == 2'b01).
module interrupt_take_sequencer (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        int_i,
  input  logic [3:0]  int_type_i,
  input  logic [1:0]  new_mode_i,
  input  logic [1:0]  current_privilege_mode_i,
  input  logic        exc_busy_i,
  input  logic        rob_empty_i,
  input  logic [31:0] resume_pc_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] stvec_i,
  output logic        halt_dispatch_o,
  output logic        busy_o,
  output logic        trap_valid_o,
  output logic [1:0]  trap_mode_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] trap_epc_o,
  output logic [1:0]  trap_prev_mode_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {StIdle, StDrain, StWrite, StRedirect} state_e;

  state_e      state_q, state_d;
  logic        latch;
  logic [31:0] tvec;
  logic [31:0] base;
  logic [31:0] target;

  logic        busy_q;
  logic        trap_valid_q;
  logic        redirect_valid_q;
  logic [1:0]  trap_mode_q;
  logic [31:0] trap_cause_q;
  logic [31:0] trap_epc_q;
  logic [1:0]  trap_prev_mode_q;
  logic [31:0] redirect_pc_q;

  // Trap vector selection and target computation, evaluated in the drain-completion cycle.
  always_comb begin
    tvec = (new_mode_i == 2'b11) ? mtvec_i : stvec_i;
    base = {tvec[31:2], 2'b00};
`ifdef INT_VECTORED_EN
    // Modes 2'b10 / 2'b11 fall back to direct.
    target = (tvec[1:0] == 2'b01) ? (base + {26'b0, int_type_i, 2'b00}) : base;
`else
    target = base;
`endif
  end

`ifndef INT_VECTORED_EN
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^tvec[1:0];
`endif

  // Next-state logic; cause and mode are captured at drain completion, not at request.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (int_i && !exc_busy_i) state_d = StDrain;
      end
      StDrain: begin
        if (!int_i) begin
          state_d = StIdle;
        end else if (rob_empty_i) begin
          latch   = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = StRedirect;
      end
      StRedirect: begin
        if (redirect_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so they align with it.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q          <= StIdle;
      busy_q           <= 1'b0;
      trap_valid_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      trap_mode_q      <= 2'b00;
      trap_cause_q     <= 32'h0;
      trap_epc_q       <= 32'h0;
      trap_prev_mode_q <= 2'b00;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      busy_q           <= (state_d != StIdle);
      trap_valid_q     <= (state_d == StWrite);
      redirect_valid_q <= (state_d == StRedirect);
      if (latch) begin
        trap_mode_q      <= new_mode_i;
        trap_cause_q     <= {1'b1, 27'b0, int_type_i};
        trap_epc_q       <= resume_pc_i;
        trap_prev_mode_q <= current_privilege_mode_i;
        redirect_pc_q    <= target;
      end
    end
  end

  assign halt_dispatch_o  = busy_q;
  assign busy_o           = busy_q;
  assign trap_valid_o     = trap_valid_q;
  assign redirect_valid_o = redirect_valid_q;
  assign trap_mode_o      = trap_mode_q;
  assign trap_cause_o     = trap_cause_q;
  assign trap_epc_o       = trap_epc_q;
  assign trap_prev_mode_o = trap_prev_mode_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_interrupt_take_sequencer.sv
// Bench for interrupt_take_sequencer: directed takes with a trap/redirect scoreboard.
// Expected redirect targets follow INT_VECTORED_EN when it is defined for the build.
module tb_interrupt_take_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_i;
  logic [3:0]  int_type;
  logic [1:0]  new_mode;
  logic [1:0]  cur_mode;
  logic        exc_busy;
  logic        rob_empty;
  logic [31:0] resume_pc;
  logic [31:0] mtvec;
  logic [31:0] stvec;
  logic        halt_dispatch;
  logic        busy;
  logic        trap_valid;
  logic [1:0]  trap_mode;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [1:0]  trap_prev_mode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  interrupt_take_sequencer dut (
    .cpu_clock_i              (clk),
    .cpu_reset_i              (rst),
    .int_i                    (int_i),
    .int_type_i               (int_type),
    .new_mode_i               (new_mode),
    .current_privilege_mode_i (cur_mode),
    .exc_busy_i               (exc_busy),
    .rob_empty_i              (rob_empty),
    .resume_pc_i              (resume_pc),
    .mtvec_i                  (mtvec),
    .stvec_i                  (stvec),
    .halt_dispatch_o          (halt_dispatch),
    .busy_o                   (busy),
    .trap_valid_o             (trap_valid),
    .trap_mode_o              (trap_mode),
    .trap_cause_o             (trap_cause),
    .trap_epc_o               (trap_epc),
    .trap_prev_mode_o         (trap_prev_mode),
    .redirect_valid_o         (redirect_valid),
    .redirect_pc_o            (redirect_pc),
    .redirect_ready_i         (redirect_ready)
  );

  always #5 clk = ~clk;

`ifdef INT_VECTORED_EN
  localparam bit Vec = 1'b1;
`else
  localparam bit Vec = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [1:0]  mode;
    logic [1:0]  prev;
  } trap_t;

  trap_t       exp_trap[$];
  logic [31:0] exp_redir[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every trap strobe and every redirect handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (trap_valid) begin
        if (exp_trap.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_trap: got cause %h expected no trap", trap_cause);
        end else begin
          trap_t e;
          e = exp_trap.pop_front();
          chk("trap_cause", trap_cause, e.cause);
          chk("trap_epc", trap_epc, e.epc);
          chk("trap_mode", {30'b0, trap_mode}, {30'b0, e.mode});
          chk("trap_prev_mode", {30'b0, trap_prev_mode}, {30'b0, e.prev});
        end
      end
      if (redirect_valid && redirect_ready) begin
        if (exp_redir.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
        end else begin
          chk("redirect_pc_hs", redirect_pc, exp_redir.pop_front());
        end
      end
    end
  end

  // Empty-ROB take with cycle-exact timing checks; leaves the DUT in REDIRECT when ready=0.
  task automatic take_fast(input logic [3:0] ty, input logic [1:0] mode, input logic [1:0] prev,
                           input logic [31:0] pc, input logic [31:0] mt, input logic [31:0] st,
                           input logic [31:0] tgt, input logic ready);
    trap_t e;
    int_type = ty; new_mode = mode; cur_mode = prev; resume_pc = pc;
    mtvec = mt; stvec = st; rob_empty = 1'b1; redirect_ready = ready; int_i = 1'b1;
    e.cause = {1'b1, 27'b0, ty}; e.epc = pc; e.mode = mode; e.prev = prev;
    exp_trap.push_back(e);
    if (ready) exp_redir.push_back(tgt);
    step();
    chk("halt_n1", {31'b0, halt_dispatch}, 32'd1);
    chk("no_trap_n1", {31'b0, trap_valid}, 32'd0);
    step();
    chk("trap_valid_n2", {31'b0, trap_valid}, 32'd1);
    int_i = 1'b0;
    step();
    chk("redirect_valid_n3", {31'b0, redirect_valid}, 32'd1);
    chk("redirect_pc_n3", redirect_pc, tgt);
    chk("trap_once", {31'b0, trap_valid}, 32'd0);
    if (ready) begin
      step();
      chk("halt_low_after_hs", {31'b0, halt_dispatch}, 32'd0);
      chk("redirect_low_after_hs", {31'b0, redirect_valid}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {25'b0, halt_dispatch, busy, trap_valid, redirect_valid, trap_mode, trap_prev_mode[0]}
              | {30'b0, trap_prev_mode}, 32'd0);
    chk({name, "_cause"}, trap_cause, 32'd0);
    chk({name, "_epc"}, trap_epc, 32'd0);
    chk({name, "_rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    rst = 1'b1; int_i = 1'b0; int_type = 4'd0; new_mode = 2'b00; cur_mode = 2'b00;
    exc_busy = 1'b0; rob_empty = 1'b0; resume_pc = 32'h0; mtvec = 32'h0; stvec = 32'h0;
    redirect_ready = 1'b1;
    step(); step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Empty-ROB take, M-mode, vectored mtvec.
    take_fast(4'd11, 2'b11, 2'b00, 32'h100, 32'h8000_0101, 32'h0,
              Vec ? 32'h8000_012C : 32'h8000_0100, 1'b1);
    step();

    // tvec mode 2'b11 is direct; vectored wrap at 2^32.
    take_fast(4'd3, 2'b11, 2'b01, 32'h204, 32'h0000_4003, 32'h0, 32'h0000_4000, 1'b1);
    take_fast(4'd11, 2'b11, 2'b11, 32'h300, 32'hFFFF_FFFD, 32'h0,
              Vec ? 32'h0000_0028 : 32'hFFFF_FFFC, 1'b1);
    // S-mode through vectored stvec.
    take_fast(4'd9, 2'b01, 2'b00, 32'h400, 32'h0, 32'h0000_3001,
              Vec ? 32'h0000_3024 : 32'h0000_3000, 1'b1);

    // Drain wait: ROB busy for 5 cycles after entering DRAIN.
    begin
      trap_t e;
      int_type = 4'd7; new_mode = 2'b11; cur_mode = 2'b00; resume_pc = 32'h200;
      mtvec = 32'h0000_1000; rob_empty = 1'b0; int_i = 1'b1;
      e.cause = 32'h8000_0007; e.epc = 32'h200; e.mode = 2'b11; e.prev = 2'b00;
      exp_trap.push_back(e);
      exp_redir.push_back(32'h0000_1000);
      step();
      for (int i = 0; i < 5; i++) begin
        chk("drain_halt", {31'b0, halt_dispatch}, 32'd1);
        chk("drain_no_trap", {31'b0, trap_valid}, 32'd0);
        step();
      end
      rob_empty = 1'b1;
      step();
      chk("drain_trap", {31'b0, trap_valid}, 32'd1);
      int_i = 1'b0;
      step(); step();
      chk("drain_done_idle", {31'b0, busy}, 32'd0);
    end

    // Withdrawal during DRAIN: no trap, back to IDLE.
    rob_empty = 1'b0; int_i = 1'b1;
    step();
    chk("wd_halt", {31'b0, halt_dispatch}, 32'd1);
    int_i = 1'b0;
    step();
    chk("wd_halt_low", {31'b0, halt_dispatch}, 32'd0);
    chk("wd_busy_low", {31'b0, busy}, 32'd0);
    rob_empty = 1'b1;
    step(); step();
    chk("wd_no_redirect", {31'b0, redirect_valid}, 32'd0);

    // exc_busy blocks a take while IDLE.
    exc_busy = 1'b1; int_i = 1'b1;
    step();
    chk("excbusy_block", {31'b0, halt_dispatch}, 32'd0);
    exc_busy = 1'b0; rob_empty = 1'b0;
    step();
    chk("excbusy_release", {31'b0, halt_dispatch}, 32'd1);
    int_i = 1'b0;
    step();

    // Priority change during drain: type 5 at request, type 9 at completion, S-mode.
    begin
      trap_t e;
      int_type = 4'd5; new_mode = 2'b01; cur_mode = 2'b00; resume_pc = 32'h500;
      stvec = 32'h0000_2000; mtvec = 32'h0000_9000; rob_empty = 1'b0; int_i = 1'b1;
      e.cause = 32'h8000_0009; e.epc = 32'h500; e.mode = 2'b01; e.prev = 2'b00;
      exp_trap.push_back(e);
      exp_redir.push_back(32'h0000_2000);
      step();
      int_type = 4'd9; rob_empty = 1'b1;
      step();
      int_i = 1'b0;
      step();
      chk("prio_redirect_pc", redirect_pc, 32'h0000_2000);
      step();
    end

    // Backpressure: ready low for 4 cycles.
    take_fast(4'd1, 2'b01, 2'b01, 32'h600, 32'h0, 32'h0000_7000, 32'h0000_7000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", {31'b0, redirect_valid}, 32'd1);
      chk("bp_pc_stable", redirect_pc, 32'h0000_7000);
      chk("bp_no_trap", {31'b0, trap_valid}, 32'd0);
    end
    exp_redir.push_back(32'h0000_7000);
    redirect_ready = 1'b1;
    step();
    chk("bp_idle", {31'b0, busy}, 32'd0);

    // Reset mid-REDIRECT, then a fresh take.
    take_fast(4'd7, 2'b11, 2'b00, 32'h700, 32'h0000_8000, 32'h0, 32'h0000_8000, 1'b0);
    rst = 1'b1;
    step();
    chk_all_zero("mid_reset");
    rst = 1'b0; redirect_ready = 1'b1;
    take_fast(4'd11, 2'b11, 2'b00, 32'h800, 32'h0000_A000, 32'h0, 32'h0000_A000, 1'b1);
    step(); step();

    chk("trap_queue_drained", exp_trap.size(), 32'd0);
    chk("redir_queue_drained", exp_redir.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
